// File: rtl/pkt_discard_stage.sv
// Packet discard stage: drops LMID-addressed packets flagged for discard, forwards the rest with
// the next-module ID, and exposes counters on the config chain. Define PDS_DROP_TS_EN for last_drop_ts.

module pds_fwft_fifo #(
    parameter int WIDTH = 256,
    parameter int DEPTH = 256,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr,
    input  logic [WIDTH-1:0] din,
    input  logic             rd,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic [AW:0]      usedw
);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp;
    logic [AW-1:0]    rp;
    logic             do_wr;
    logic             do_rd;

    assign empty = (usedw == '0);
    assign do_wr = wr && (usedw != FULL);
    assign do_rd = rd && !empty;
    assign dout  = mem[rp];

    always_ff @(posedge clk) begin
        if (do_wr) mem[wp] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp    <= '0;
            rp    <= '0;
            usedw <= '0;
        end else begin
            if (do_wr) wp <= wp + AW'(1);
            if (do_rd) rp <= rp + AW'(1);
            case ({do_wr, do_rd})
                2'b10:   usedw <= usedw + (AW+1)'(1);
                2'b01:   usedw <= usedw - (AW+1)'(1);
                default: usedw <= usedw;
            endcase
        end
    end
endmodule

module pkt_discard_stage #(
    parameter logic [7:0] LMID       = 8'd5,
    parameter logic [7:0] NMID       = 8'd6,
    parameter int         FIFO_DEPTH = 256,
    parameter int         ALF_MARGIN = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [255:0]  in_pds_md,
    input  logic          in_pds_md_wr,
    output logic          out_pds_md_alf,
    input  logic [1023:0] in_pds_phv,
    input  logic          in_pds_phv_wr,
    output logic          out_pds_phv_alf,
    output logic [255:0]  out_pds_md,
    output logic          out_pds_md_wr,
    input  logic          in_pds_md_alf,
    output logic [1023:0] out_pds_phv,
    output logic          out_pds_phv_wr,
    input  logic          in_pds_phv_alf,
    input  logic [133:0]  cin_pds_data,
    input  logic          cin_pds_data_wr,
    output logic          cout_pds_ready,
    output logic [133:0]  cout_pds_data,
    output logic          cout_pds_data_wr,
    input  logic          cin_pds_ready
);
    localparam int          AW     = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] ALF_TH = (AW+1)'(FIFO_DEPTH - ALF_MARGIN);

    typedef enum logic {IDLE, SEND} state_t;
    state_t state, next_state;

    logic [255:0]  md_head, md_q, md_fwd;
    logic [1023:0] phv_head, phv_q;
    logic          md_empty, phv_empty, pop;
    logic [AW:0]   md_usedw, phv_usedw, max_usedw;
    logic          hit, drop, fwd, discard_en;
    logic [31:0]   fwd_pkt_cnt, drop_pkt_cnt, drop_byte_cnt;

    logic          cfg_acc, cfg_is_hdr, cfg_is_tail, cfg_mid;
    logic          cfg_wr_hit, cfg_rd_hit, addr_ok, ctrl_wr, cnt_clr;
    logic          swallow_tail, consume;
    logic [3:0]    cfg_off;
    logic [31:0]   rd_val;
    logic [133:0]  rsp;

    pds_fwft_fifo #(.WIDTH(256), .DEPTH(FIFO_DEPTH)) u_md_fifo (
        .clk(clk), .rst_n(rst_n), .wr(in_pds_md_wr), .din(in_pds_md), .rd(pop),
        .dout(md_head), .empty(md_empty), .usedw(md_usedw)
    );

    pds_fwft_fifo #(.WIDTH(1024), .DEPTH(FIFO_DEPTH)) u_phv_fifo (
        .clk(clk), .rst_n(rst_n), .wr(in_pds_phv_wr), .din(in_pds_phv), .rd(pop),
        .dout(phv_head), .empty(phv_empty), .usedw(phv_usedw)
    );

    assign max_usedw       = (md_usedw > phv_usedw) ? md_usedw : phv_usedw;
    assign out_pds_md_alf  = in_pds_md_alf | in_pds_phv_alf | (max_usedw > ALF_TH);
    assign out_pds_phv_alf = out_pds_md_alf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // A packet is only popped when both halves are present and downstream can take it.
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!md_empty && !phv_empty && !in_pds_md_alf && !in_pds_phv_alf) begin
                    pop        = 1'b1;
                    next_state = SEND;
                end
            end
            SEND:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md_q  <= '0;
            phv_q <= '0;
        end else if (pop) begin
            md_q  <= md_head;
            phv_q <= phv_head;
        end
    end

    assign hit  = (state == SEND) && (md_q[87:80] == LMID);
    assign drop = hit && md_q[108] && discard_en;
    assign fwd  = (state == SEND) && !drop;

    always_comb begin
        md_fwd = md_q;
        if (hit) md_fwd[87:80] = NMID;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_pds_md_wr  <= 1'b0;
            out_pds_phv_wr <= 1'b0;
            out_pds_md     <= '0;
            out_pds_phv    <= '0;
        end else begin
            out_pds_md_wr  <= fwd;
            out_pds_phv_wr <= fwd;
            out_pds_md     <= fwd ? md_fwd : '0;
            out_pds_phv    <= fwd ? phv_q : '0;
        end
    end

    assign cout_pds_ready = cin_pds_ready;
    assign cfg_acc     = cin_pds_data_wr & cin_pds_ready;
    assign cfg_is_hdr  = (cin_pds_data[133:132] == 2'b01);
    assign cfg_is_tail = (cin_pds_data[133:132] == 2'b10);
    assign cfg_mid     = (cin_pds_data[103:96] == LMID);
    assign cfg_wr_hit  = cfg_acc && cfg_is_hdr && cfg_mid && (cin_pds_data[126:124] == 3'b010);
    assign cfg_rd_hit  = cfg_acc && cfg_is_hdr && cfg_mid && (cin_pds_data[126:124] == 3'b001);
    assign addr_ok     = (cin_pds_data[95:68] == {LMID[3:0], 24'h0});
    assign cfg_off     = cin_pds_data[67:64];
    assign ctrl_wr     = cfg_wr_hit && addr_ok && (cfg_off == 4'd0);
    assign cnt_clr     = ctrl_wr && cin_pds_data[1];
    assign consume     = cfg_wr_hit || (cfg_acc && cfg_is_tail && swallow_tail);

`ifdef PDS_DROP_TS_EN
    logic [31:0] last_drop_ts;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       last_drop_ts <= '0;
        else if (cnt_clr) last_drop_ts <= '0;
        else if (drop)    last_drop_ts <= md_q[31:0];
    end
`endif

    always_comb begin
        rd_val = '0;
        if (addr_ok) begin
            case (cfg_off)
                4'd0:    rd_val = {31'd0, discard_en};
                4'd1:    rd_val = fwd_pkt_cnt;
                4'd2:    rd_val = drop_pkt_cnt;
                4'd3:    rd_val = drop_byte_cnt;
`ifdef PDS_DROP_TS_EN
                4'd4:    rd_val = last_drop_ts;
`endif
                default: rd_val = '0;
            endcase
        end
    end

    always_comb begin
        rsp          = cin_pds_data;
        rsp[127:124] = 4'b1011;
        rsp[111:104] = cin_pds_data[103:96];
        rsp[103:96]  = cin_pds_data[111:104];
        rsp[31:0]    = rd_val;
    end

    // Clear takes priority so a clear landing on an increment leaves the counter at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_pkt_cnt   <= '0;
            drop_pkt_cnt  <= '0;
            drop_byte_cnt <= '0;
        end else if (cnt_clr) begin
            fwd_pkt_cnt   <= '0;
            drop_pkt_cnt  <= '0;
            drop_byte_cnt <= '0;
        end else begin
            if (fwd) fwd_pkt_cnt <= fwd_pkt_cnt + 32'd1;
            if (drop) begin
                drop_pkt_cnt  <= drop_pkt_cnt + 32'd1;
                drop_byte_cnt <= drop_byte_cnt + {20'd0, md_q[107:96]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            discard_en   <= 1'b1;
            swallow_tail <= 1'b0;
        end else begin
            if (ctrl_wr) discard_en <= cin_pds_data[0];
            if (cfg_wr_hit)   swallow_tail <= 1'b1;
            else if (consume) swallow_tail <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cout_pds_data_wr <= 1'b0;
            cout_pds_data    <= '0;
        end else begin
            cout_pds_data_wr <= cfg_acc && !consume;
            cout_pds_data    <= (cfg_acc && !consume) ? (cfg_rd_hit ? rsp : cin_pds_data) : '0;
        end
    end
endmodule

// File: tb/tb_pkt_discard_stage.sv
// Directed testbench for pkt_discard_stage: packet forward/drop, counters over the config
// chain, backpressure, clear/enable collisions, foreign config flits and mid-packet reset.
`timescale 1ns/1ps

module tb_pkt_discard_stage;
    localparam logic [7:0] LMID = 8'd5;
    localparam logic [7:0] NMID = 8'd6;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [255:0]  in_pds_md;
    logic          in_pds_md_wr;
    logic          out_pds_md_alf;
    logic [1023:0] in_pds_phv;
    logic          in_pds_phv_wr;
    logic          out_pds_phv_alf;
    logic [255:0]  out_pds_md;
    logic          out_pds_md_wr;
    logic          in_pds_md_alf;
    logic [1023:0] out_pds_phv;
    logic          out_pds_phv_wr;
    logic          in_pds_phv_alf;
    logic [133:0]  cin_pds_data;
    logic          cin_pds_data_wr;
    logic          cout_pds_ready;
    logic [133:0]  cout_pds_data;
    logic          cout_pds_data_wr;
    logic          cin_pds_ready;

    int checks = 0;
    int errors = 0;

    logic [255:0]  md_q[$];
    logic [1023:0] phv_q[$];
    logic [133:0]  cfg_q[$];

    pkt_discard_stage dut (
        .clk(clk), .rst_n(rst_n),
        .in_pds_md(in_pds_md), .in_pds_md_wr(in_pds_md_wr), .out_pds_md_alf(out_pds_md_alf),
        .in_pds_phv(in_pds_phv), .in_pds_phv_wr(in_pds_phv_wr), .out_pds_phv_alf(out_pds_phv_alf),
        .out_pds_md(out_pds_md), .out_pds_md_wr(out_pds_md_wr), .in_pds_md_alf(in_pds_md_alf),
        .out_pds_phv(out_pds_phv), .out_pds_phv_wr(out_pds_phv_wr), .in_pds_phv_alf(in_pds_phv_alf),
        .cin_pds_data(cin_pds_data), .cin_pds_data_wr(cin_pds_data_wr), .cout_pds_ready(cout_pds_ready),
        .cout_pds_data(cout_pds_data), .cout_pds_data_wr(cout_pds_data_wr), .cin_pds_ready(cin_pds_ready)
    );

    always #5 clk = ~clk;

    // Capture every output strobe mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (out_pds_md_wr)    md_q.push_back(out_pds_md);
        if (out_pds_phv_wr)   phv_q.push_back(out_pds_phv);
        if (cout_pds_data_wr) cfg_q.push_back(cout_pds_data);
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [255:0] make_md(input logic [7:0] mid, input logic disc,
                                             input logic [11:0] len, input logic [31:0] tag);
        logic [255:0] m;
        m          = '0;
        m[255:224] = ~tag;
        m[87:80]   = mid;
        m[108]     = disc;
        m[107:96]  = len;
        m[63:32]   = {tag[15:0], 16'hBEEF};
        m[31:0]    = tag;
        return m;
    endfunction

    function automatic logic [1023:0] make_phv(input logic [31:0] tag);
        logic [1023:0] p;
        p            = '0;
        p[1023:992]  = tag;
        p[511:480]   = ~tag;
        p[31:0]      = tag ^ 32'h5A5A_5A5A;
        return p;
    endfunction

    function automatic logic [133:0] cfg_hdr(input logic [2:0] typ, input logic [7:0] dst,
                                             input logic [31:0] addr, input logic [31:0] data);
        logic [133:0] h;
        h           = '0;
        h[133:132]  = 2'b01;
        h[126:124]  = typ;
        h[111:104]  = 8'h01;
        h[103:96]   = dst;
        h[95:64]    = addr;
        h[31:0]     = data;
        return h;
    endfunction

    function automatic logic [133:0] cfg_tail(input logic [63:0] payload);
        logic [133:0] t;
        t          = '0;
        t[133:132] = 2'b10;
        t[63:0]    = payload;
        return t;
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [255:0] md, input logic [1023:0] phv, input bit w_md, input bit w_phv);
        in_pds_md     = md;
        in_pds_phv    = phv;
        in_pds_md_wr  = w_md;
        in_pds_phv_wr = w_phv;
        tick();
        in_pds_md_wr  = 1'b0;
        in_pds_phv_wr = 1'b0;
        in_pds_md     = '0;
        in_pds_phv    = '0;
    endtask

    task automatic send_flit(input logic [133:0] f);
        cin_pds_data    = f;
        cin_pds_data_wr = 1'b1;
        tick();
        cin_pds_data_wr = 1'b0;
        cin_pds_data    = '0;
    endtask

    task automatic cfg_write(input logic [3:0] off, input logic [31:0] data);
        send_flit(cfg_hdr(3'b010, LMID, 32'h5000_0000 | {28'd0, off}, data));
        send_flit(cfg_tail(64'h0000_0000_DEAD_0001));
    endtask

    task automatic cfg_read(input logic [3:0] off, output logic [133:0] rsp, output logic [133:0] tl);
        cfg_q.delete();
        send_flit(cfg_hdr(3'b001, LMID, 32'h5000_0000 | {28'd0, off}, 32'd0));
        send_flit(cfg_tail(64'h7A11_0000_0000_0000 | {60'd0, off}));
        for (int i = 0; i < 8 && cfg_q.size() < 2; i++) tick();
        rsp = 'x;
        tl  = 'x;
        if (cfg_q.size() >= 2) begin
            rsp = cfg_q[0];
            tl  = cfg_q[1];
        end
    endtask

    task automatic test_reset();
        logic [133:0] rsp, tl;
        $display("[TB] test_reset");
        rst_n = 1'b0;
        tick(3);
        checks++;
        if (out_pds_md_wr !== 1'b0 || out_pds_phv_wr !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_pkt_wr: got md_wr=%b phv_wr=%b expected 0", out_pds_md_wr, out_pds_phv_wr);
        end
        checks++;
        if (out_pds_md !== '0 || out_pds_phv !== '0) begin
            errors++;
            $display("[TB] FAIL reset_pkt_data: got md=%h expected 0", out_pds_md);
        end
        checks++;
        if (cout_pds_data_wr !== 1'b0 || cout_pds_data !== '0) begin
            errors++;
            $display("[TB] FAIL reset_cfg_out: got wr=%b data=%h expected 0", cout_pds_data_wr, cout_pds_data);
        end
        checks++;
        if (out_pds_md_alf !== 1'b0 || out_pds_phv_alf !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_alf: got %b/%b expected 0/0", out_pds_md_alf, out_pds_phv_alf);
        end
        rst_n = 1'b1;
        tick(2);
        cfg_read(4'd0, rsp, tl);
        checks++;
        if (rsp[31:0] !== 32'd1) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got %h expected 00000001", rsp[31:0]);
        end
        cfg_read(4'd1, rsp, tl);
        checks++;
        if (rsp[31:0] !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_fwd_cnt: got %h expected 0", rsp[31:0]);
        end
    endtask

    task automatic test_pass_through();
        logic [255:0]  exp_md  [4];
        logic [1023:0] exp_phv [4];
        logic [255:0]  got_md;
        logic [1023:0] got_phv;
        logic [133:0]  rsp, tl;
        $display("[TB] test_pass_through");
        md_q.delete();
        phv_q.delete();
        for (int i = 0; i < 4; i++) begin
            exp_md[i]  = make_md(8'd9, 1'b1, 12'd64 + 12'(i), 32'h1000 + i);
            exp_phv[i] = make_phv(32'h1000 + i);
            push(exp_md[i], exp_phv[i], 1'b1, 1'b1);
        end
        tick(20);
        checks++;
        if (md_q.size() != 4 || phv_q.size() != 4) begin
            errors++;
            $display("[TB] FAIL pass_count: got md=%0d phv=%0d expected 4/4", md_q.size(), phv_q.size());
        end
        for (int i = 0; i < 4; i++) begin
            got_md  = (i < md_q.size())  ? md_q[i]  : 'x;
            got_phv = (i < phv_q.size()) ? phv_q[i] : 'x;
            checks++;
            if (got_md !== exp_md[i]) begin
                errors++;
                $display("[TB] FAIL pass_md[%0d]: got %h expected %h", i, got_md, exp_md[i]);
            end
            checks++;
            if (got_phv !== exp_phv[i]) begin
                errors++;
                $display("[TB] FAIL pass_phv[%0d]: got tag %h expected tag %h", i, got_phv[1023:992], exp_phv[i][1023:992]);
            end
        end
        cfg_read(4'd1, rsp, tl);
        checks++;
        if (rsp[31:0] !== 32'd4) begin
            errors++;
            $display("[TB] FAIL pass_fwd_cnt: got %0d expected 4", rsp[31:0]);
        end
        cfg_read(4'd2, rsp, tl);
        checks++;
        if (rsp[31:0] !== 32'd0) begin
            errors++;
            $display("[TB] FAIL pass_drop_cnt: got %0d expected 0", rsp[31:0]);
        end
    endtask

    task automatic test_drop();
        logic [255:0] exp_md [2];
        logic [255:0] got_md;
        logic [133:0] rsp, tl, exp_rsp, exp_tl;
        $display("[TB] test_drop");
        cfg_q.delete();
        cfg_write(4'd0, 32'h3);
        tick(3);
        checks++;
        if (cfg_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL drop_clear_silent: got %0d cfg flits expected 0", cfg_q.size());
        end
        md_q.delete();
        phv_q.delete();
        for (int i = 0; i < 5; i++) begin
            if (i % 2 == 0) push(make_md(LMID, 1'b1, 12'd100, 32'h3000 + i), make_phv(32'h3000 + i), 1'b1, 1'b1);
            else            push(make_md(LMID, 1'b0, 12'd40, 32'h3000 + i), make_phv(32'h3000 + i), 1'b1, 1'b1);
        end
        exp_md[0] = make_md(NMID, 1'b0, 12'd40, 32'h3001);
        exp_md[1] = make_md(NMID, 1'b0, 12'd40, 32'h3003);
        tick(20);
        checks++;
        if (md_q.size() != 2 || phv_q.size() != 2) begin
            errors++;
            $display("[TB] FAIL drop_fwd_count: got md=%0d phv=%0d expected 2/2", md_q.size(), phv_q.size());
        end
        for (int i = 0; i < 2; i++) begin
            got_md = (i < md_q.size()) ? md_q[i] : 'x;
            checks++;
            if (got_md !== exp_md[i]) begin
                errors++;
                $display("[TB] FAIL drop_fwd_md[%0d]: got %h expected %h", i, got_md, exp_md[i]);
            end
        end
        cfg_read(4'd2, rsp, tl);
        exp_rsp          = cfg_hdr(3'b001, LMID, 32'h5000_0002, 32'd0);
        exp_rsp[127:124] = 4'b1011;
        exp_rsp[111:104] = LMID;
        exp_rsp[103:96]  = 8'h01;
        exp_rsp[31:0]    = 32'd3;
        exp_tl           = cfg_tail(64'h7A11_0000_0000_0002);
        checks++;
        if (rsp !== exp_rsp) begin
            errors++;
            $display("[TB] FAIL drop_pkt_rsp: got %h expected %h", rsp, exp_rsp);
        end
        checks++;
        if (tl !== exp_tl) begin
            errors++;
            $display("[TB] FAIL drop_rsp_tail: got %h expected %h", tl, exp_tl);
        end
        cfg_read(4'd3, rsp, tl);
        checks++;
        if (rsp[31:0] !== 32'd300) begin
            errors++;
            $display("[TB] FAIL drop_byte_cnt: got %0d expected 300", rsp[31:0]);
        end
        cfg_read(4'd1, rsp, tl);
        checks++;
        if (rsp[31:0] !== 32'd2) begin
            errors++;
            $display("[TB] FAIL drop_fwd_cnt: got %0d expected 2", rsp[31:0]);
        end
    endtask

    task automatic test_discard_disable();
        logic [255:0] got_md;
        logic [133:0] rsp, tl;
        $display("[TB] test_discard_disable");
        cfg_q.delete();
        cfg_write(4'd0, 32'h0);
        tick(3);
        checks++;
        if (cfg_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL dis_write_silent: got %0d cfg flits expected 0", cfg_q.size());
        end
        md_q.delete();
        phv_q.delete();
        for (int i = 0; i < 2; i++) push(make_md(LMID, 1'b1, 12'd20, 32'h4000 + i), make_phv(32'h4000 + i), 1'b1, 1'b1);
        tick(12);
        checks++;
        if (md_q.size() != 2) begin
            errors++;
            $display("[TB] FAIL dis_fwd_count: got %0d expected 2", md_q.size());
        end
        for (int i = 0; i < 2; i++) begin
            got_md = (i < md_q.size()) ? md_q[i] : 'x;
            checks++;
            if (got_md !== make_md(NMID, 1'b1, 12'd20, 32'h4000 + i)) begin
                errors++;
                $display("[TB] FAIL dis_fwd_md[%0d]: got %h expected %h", i, got_md, make_md(NMID, 1'b1, 12'd20, 32'h4000 + i));
            end
        end
        cfg_read(4'd0, rsp, tl);
        checks++;
        if (rsp[31:0] !== 32'd0) begin
            errors++;
            $display("[TB] FAIL dis_ctrl: got %h expected 0", rsp[31:0]);
        end
        cfg_write(4'd0, 32'h1);
        cfg_read(4'd1, rsp, tl);
        checks++;
        if (rsp[31:0] !== 32'd4) begin
            errors++;
            $display("[TB] FAIL dis_fwd_cnt: got %0d expected 4", rsp[31:0]);
        end
    endtask

    task automatic test_clear_collision();
        logic [133:0] rsp, tl;
        logic [31:0]  exp_ts;
        $display("[TB] test_clear_collision");
        tick(5);
        md_q.delete();
        // Packet written in cycle X is in SEND during X+2; the clear header lands in that cycle.
        push(make_md(LMID, 1'b1, 12'd77, 32'h5000), make_phv(32'h5000), 1'b1, 1'b1);
        tick();
        send_flit(cfg_hdr(3'b010, LMID, 32'h5000_0000, 32'h3));
        send_flit(cfg_tail(64'h1));
        tick(5);
        checks++;
        if (md_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL clr_no_fwd: got %0d packets expected 0", md_q.size());
        end
        cfg_read(4'd2, rsp, tl);
        checks++;
        if (rsp[31:0] !== 32'd0) begin
            errors++;
            $display("[TB] FAIL clr_drop_cnt: got %0d expected 0", rsp[31:0]);
        end
        cfg_read(4'd3, rsp, tl);
        checks++;
        if (rsp[31:0] !== 32'd0) begin
            errors++;
            $display("[TB] FAIL clr_byte_cnt: got %0d expected 0", rsp[31:0]);
        end
        push(make_md(LMID, 1'b1, 12'd50, 32'h5100), make_phv(32'h5100), 1'b1, 1'b1);
        tick();
        send_flit(cfg_hdr(3'b010, LMID, 32'h5000_0000, 32'h0));
        send_flit(cfg_tail(64'h2));
        tick(5);
        checks++;
        if (md_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL en_old_value: got %0d packets expected 0", md_q.size());
        end
        cfg_read(4'd2, rsp, tl);
        checks++;
        if (rsp[31:0] !== 32'd1) begin
            errors++;
            $display("[TB] FAIL en_drop_cnt: got %0d expected 1", rsp[31:0]);
        end
        cfg_read(4'd3, rsp, tl);
        checks++;
        if (rsp[31:0] !== 32'd50) begin
            errors++;
            $display("[TB] FAIL en_byte_cnt: got %0d expected 50", rsp[31:0]);
        end
        cfg_read(4'd0, rsp, tl);
        checks++;
        if (rsp[31:0] !== 32'd0) begin
            errors++;
            $display("[TB] FAIL en_ctrl: got %h expected 0", rsp[31:0]);
        end
        cfg_write(4'd0, 32'h1);
`ifdef PDS_DROP_TS_EN
        exp_ts = 32'h5100;
`else
        exp_ts = 32'h0;
`endif
        cfg_read(4'd4, rsp, tl);
        checks++;
        if (rsp[31:0] !== exp_ts) begin
            errors++;
            $display("[TB] FAIL drop_ts: got %h expected %h", rsp[31:0], exp_ts);
        end
    endtask

    task automatic test_backpressure();
        logic [255:0]  got_md;
        logic [1023:0] got_phv;
        $display("[TB] test_backpressure");
        tick(5);
        md_q.delete();
        phv_q.delete();
        for (int i = 0; i < 250; i++) push(make_md(8'd9, 1'b0, 12'd1, 32'h2000 + i), '0, 1'b1, 1'b0);
        tick();
        checks++;
        if (out_pds_md_alf !== 1'b0 || out_pds_phv_alf !== 1'b0) begin
            errors++;
            $display("[TB] FAIL alf_at_250: got %b/%b expected 0/0", out_pds_md_alf, out_pds_phv_alf);
        end
        push(make_md(8'd9, 1'b0, 12'd1, 32'h2000 + 250), '0, 1'b1, 1'b0);
        checks++;
        if (out_pds_md_alf !== 1'b1 || out_pds_phv_alf !== 1'b1) begin
            errors++;
            $display("[TB] FAIL alf_at_251: got %b/%b expected 1/1", out_pds_md_alf, out_pds_phv_alf);
        end
        in_pds_md_alf = 1'b1;
        for (int i = 0; i < 251; i++) push('0, make_phv(32'h2000 + i), 1'b0, 1'b1);
        tick(5);
        checks++;
        if (md_q.size() != 0 || phv_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL bp_hold: got md=%0d phv=%0d writes expected 0", md_q.size(), phv_q.size());
        end
        in_pds_md_alf = 1'b0;
        for (int i = 0; i < 700 && md_q.size() < 251; i++) tick();
        tick(4);
        checks++;
        if (md_q.size() != 251 || phv_q.size() != 251) begin
            errors++;
            $display("[TB] FAIL bp_drain_count: got md=%0d phv=%0d expected 251", md_q.size(), phv_q.size());
        end
        for (int i = 0; i < 251; i++) begin
            got_md  = (i < md_q.size())  ? md_q[i]  : 'x;
            got_phv = (i < phv_q.size()) ? phv_q[i] : 'x;
            checks++;
            if (got_md !== make_md(8'd9, 1'b0, 12'd1, 32'h2000 + i) || got_phv !== make_phv(32'h2000 + i)) begin
                errors++;
                $display("[TB] FAIL bp_order[%0d]: got tags %h/%h expected %h", i, got_md[31:0], got_phv[1023:992], 32'h2000 + i);
            end
        end
        checks++;
        if (out_pds_md_alf !== 1'b0) begin
            errors++;
            $display("[TB] FAIL alf_after_drain: got %b expected 0", out_pds_md_alf);
        end
    endtask

    task automatic test_foreign_config();
        logic [133:0] hdr, tl;
        $display("[TB] test_foreign_config");
        hdr = cfg_hdr(3'b001, 8'd7, 32'h7000_0001, 32'h0000_1234);
        tl  = cfg_tail(64'hFEED_0000_0000_0007);
        cin_pds_data    = hdr;
        cin_pds_data_wr = 1'b1;
        tick();
        cin_pds_data = tl;
        checks++;
        if (cout_pds_data_wr !== 1'b1 || cout_pds_data !== hdr) begin
            errors++;
            $display("[TB] FAIL foreign_hdr: got wr=%b %h expected 1 %h", cout_pds_data_wr, cout_pds_data, hdr);
        end
        tick();
        cin_pds_data_wr = 1'b0;
        cin_pds_data    = '0;
        checks++;
        if (cout_pds_data_wr !== 1'b1 || cout_pds_data !== tl) begin
            errors++;
            $display("[TB] FAIL foreign_tail: got wr=%b %h expected 1 %h", cout_pds_data_wr, cout_pds_data, tl);
        end
        tick();
        checks++;
        if (cout_pds_data_wr !== 1'b0 || cout_pds_data !== '0) begin
            errors++;
            $display("[TB] FAIL foreign_idle: got wr=%b %h expected 0", cout_pds_data_wr, cout_pds_data);
        end
        cin_pds_ready = 1'b0;
        #1;
        checks++;
        if (cout_pds_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ready_follow: got %b expected 0", cout_pds_ready);
        end
        send_flit(hdr);
        checks++;
        if (cout_pds_data_wr !== 1'b0) begin
            errors++;
            $display("[TB] FAIL not_ready_accept: got wr=%b expected 0", cout_pds_data_wr);
        end
        cin_pds_ready = 1'b1;
    endtask

    task automatic test_mid_packet_reset();
        logic [133:0] rsp, tl;
        logic [255:0] exp_a;
        $display("[TB] test_mid_packet_reset");
        cfg_write(4'd0, 32'h0);
        tick(3);
        md_q.delete();
        exp_a = make_md(8'd9, 1'b0, 12'd8, 32'h6000);
        push(exp_a, make_phv(32'h6000), 1'b1, 1'b1);
        push(make_md(8'd9, 1'b0, 12'd8, 32'h6001), make_phv(32'h6001), 1'b1, 1'b1);
        tick();
        checks++;
        if (out_pds_md_wr !== 1'b1 || out_pds_md !== exp_a) begin
            errors++;
            $display("[TB] FAIL latency_2: got wr=%b md=%h expected 1 %h", out_pds_md_wr, out_pds_md, exp_a);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_pds_md_wr !== 1'b0 || out_pds_md !== '0 || out_pds_phv_wr !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_reset: got wr=%b md=%h expected 0", out_pds_md_wr, out_pds_md);
        end
        tick(2);
        rst_n = 1'b1;
        tick(10);
        checks++;
        if (md_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL reset_flush: got %0d packets expected 0", md_q.size());
        end
        cfg_read(4'd0, rsp, tl);
        checks++;
        if (rsp[31:0] !== 32'd1) begin
            errors++;
            $display("[TB] FAIL reset_en_restore: got %h expected 1", rsp[31:0]);
        end
        cfg_read(4'd1, rsp, tl);
        checks++;
        if (rsp[31:0] !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_cnt_clear: got %0d expected 0", rsp[31:0]);
        end
    endtask

    initial begin
        rst_n           = 1'b0;
        in_pds_md       = '0;
        in_pds_md_wr    = 1'b0;
        in_pds_phv      = '0;
        in_pds_phv_wr   = 1'b0;
        in_pds_md_alf   = 1'b0;
        in_pds_phv_alf  = 1'b0;
        cin_pds_data    = '0;
        cin_pds_data_wr = 1'b0;
        cin_pds_ready   = 1'b1;
        test_reset();
        test_pass_through();
        test_drop();
        test_discard_disable();
        test_clear_collision();
        test_backpressure();
        test_foreign_config();
        test_mid_packet_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
